// File: rtl/pifo_dispatch_pkg.sv
// Shared types and defaults for the PIFO bypass dispatcher: FSM state encoding,
// default info width and default checker-response timeout.
package pifo_dispatch_pkg;

  localparam int DEF_PIFO_INFO_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BYP  = 2'd2,
    CAL  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/dispatch_stat_counter.sv
// Saturating event counter, +1 per cycle with inc high, sticks at all-ones.
// Latency: count visible the cycle after the event; no backpressure.
module dispatch_stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pifo_bypass_dispatcher.sv
// Holds one PIFO info word, asks the bypass checker, then emits it on the bypass or calendar channel;
// min 2 cycles capture-to-output, upstream stalled while an item is in flight. Stats under DISPATCH_STATS_EN.
module pifo_bypass_dispatcher
  import pifo_dispatch_pkg::*;
#(
  parameter int PIFO_INFO_WIDTH = DEF_PIFO_INFO_WIDTH,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_axis_valid,
  input  logic [PIFO_INFO_WIDTH-1:0] s_axis_pifo_info,
  output logic                       s_axis_ready,
  output logic                       m_chk_valid,
  output logic [PIFO_INFO_WIDTH-1:0] m_chk_pifo_info,
  input  logic                       s_chk_valid,
  input  logic                       s_chk_bypass_en,
  output logic                       m_byp_valid,
  output logic [PIFO_INFO_WIDTH-1:0] m_byp_pifo_info,
  input  logic                       m_byp_ready,
  output logic                       m_cal_valid,
  output logic [PIFO_INFO_WIDTH-1:0] m_cal_pifo_info,
  input  logic                       m_cal_ready
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                stat_bypass_cnt,
  output logic [31:0]                stat_enq_cnt,
  output logic [15:0]                stat_timeout_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  disp_state_t                state_q, state_d;
  logic [PIFO_INFO_WIDTH-1:0] hold_q;
  logic [CNT_W-1:0]           tmo_q;
  logic                       run_q;
  logic                       accept;
  logic                       expire;

  // run_q keeps ready low while in reset and until the first edge after release
  assign s_axis_ready = run_q && (state_q == IDLE);
  assign accept       = s_axis_valid && s_axis_ready;
  assign expire       = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign m_chk_valid     = (state_q == WAIT) && (tmo_q == '0);
  assign m_chk_pifo_info = hold_q;
  assign m_byp_valid     = (state_q == BYP);
  assign m_byp_pifo_info = hold_q;
  assign m_cal_valid     = (state_q == CAL);
  assign m_cal_pifo_info = hold_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      // a response always beats expiry in the same cycle
      WAIT: begin
        if (s_chk_valid)  state_d = s_chk_bypass_en ? BYP : CAL;
        else if (expire)  state_d = CAL;
      end
      BYP:  if (m_byp_ready) state_d = IDLE;
      CAL:  if (m_cal_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      tmo_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (accept) hold_q <= s_axis_pifo_info;
      if (state_q == WAIT) tmo_q <= tmo_q + CNT_W'(1);
      else                 tmo_q <= '0;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic byp_hs, cal_hs, tmo_evt;

  assign byp_hs  = (state_q == BYP) && m_byp_ready;
  assign cal_hs  = (state_q == CAL) && m_cal_ready;
  assign tmo_evt = (state_q == WAIT) && !s_chk_valid && expire;

  dispatch_stat_counter #(.WIDTH(32)) u_byp_cnt (
    .clk(clk), .rstn(rstn), .inc(byp_hs), .cnt(stat_bypass_cnt)
  );
  dispatch_stat_counter #(.WIDTH(32)) u_enq_cnt (
    .clk(clk), .rstn(rstn), .inc(cal_hs), .cnt(stat_enq_cnt)
  );
  dispatch_stat_counter #(.WIDTH(16)) u_tmo_cnt (
    .clk(clk), .rstn(rstn), .inc(tmo_evt), .cnt(stat_timeout_cnt)
  );
`endif

endmodule

// File: tb/tb_pifo_bypass_dispatcher.sv
// Bench for pifo_bypass_dispatcher: vector table, hand sequences for reset/stray/timeout corners,
// and 100 random back-to-back items checked against a transaction-level model.
module tb_pifo_bypass_dispatcher;

  localparam int W  = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_axis_valid;
  logic [W-1:0]  s_axis_pifo_info;
  logic          s_axis_ready;
  logic          m_chk_valid;
  logic [W-1:0]  m_chk_pifo_info;
  logic          s_chk_valid;
  logic          s_chk_bypass_en;
  logic          m_byp_valid;
  logic [W-1:0]  m_byp_pifo_info;
  logic          m_byp_ready;
  logic          m_cal_valid;
  logic [W-1:0]  m_cal_pifo_info;
  logic          m_cal_ready;
`ifdef DISPATCH_STATS_EN
  logic [31:0]   stat_bypass_cnt;
  logic [31:0]   stat_enq_cnt;
  logic [15:0]   stat_timeout_cnt;
`endif

  always #5 clk = ~clk;

  pifo_bypass_dispatcher #(.PIFO_INFO_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_valid(s_axis_valid), .s_axis_pifo_info(s_axis_pifo_info), .s_axis_ready(s_axis_ready),
    .m_chk_valid(m_chk_valid), .m_chk_pifo_info(m_chk_pifo_info),
    .s_chk_valid(s_chk_valid), .s_chk_bypass_en(s_chk_bypass_en),
    .m_byp_valid(m_byp_valid), .m_byp_pifo_info(m_byp_pifo_info), .m_byp_ready(m_byp_ready),
    .m_cal_valid(m_cal_valid), .m_cal_pifo_info(m_cal_pifo_info), .m_cal_ready(m_cal_ready)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_bypass_cnt(stat_bypass_cnt), .stat_enq_cnt(stat_enq_cnt), .stat_timeout_cnt(stat_timeout_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int m_byp = 0, m_cal = 0, m_tmo = 0;  // model event counts since last reset

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef DISPATCH_STATS_EN
    chk({tag, "_stat_byp"}, stat_bypass_cnt, m_byp);
    chk({tag, "_stat_enq"}, stat_enq_cnt, m_cal);
    chk({tag, "_stat_tmo"}, stat_timeout_cnt, m_tmo);
`endif
  endtask

  // Expected outcome from the rules: response within the window decides, otherwise calendar.
  function automatic int exp_channel(input int d, input logic byp);
    return (d < TO) ? (byp ? 0 : 1) : 1;
  endfunction
  function automatic int exp_latency(input int d);
    return (d < TO) ? d + 2 : TO + 1;
  endfunction
  task automatic model_count(input int d, input logic byp);
    if (exp_channel(d, byp) == 0) m_byp++; else m_cal++;
    if (d >= TO) m_tmo++;
  endtask

  // One item: present info, answer d cycles after the pulse, stall output ready for `stall` cycles.
  // ch: 0 = bypass, 1 = calendar; lat: cycles from capture edge to first output-valid cycle.
  task automatic do_item(input logic [W-1:0] info, input int d, input logic byp, input int stall,
                         input bit stray, input bit nxt_vld, input logic [W-1:0] nxt,
                         output int ch, output logic [W-1:0] data, output int lat);
    int  k;
    bit  seen, done;
    ch = -1; lat = -1; data = '0; seen = 0; done = 0;
    k = 0;
    while (!s_axis_ready && k < 50) begin @(negedge clk); k++; end
    chk("axis_ready_idle", s_axis_ready, 1'b1);
    s_axis_valid     = 1'b1;
    s_axis_pifo_info = info;
    @(negedge clk);
    s_axis_valid     = nxt_vld;
    s_axis_pifo_info = nxt;
    for (k = 1; k <= 60 && !done; k++) begin
      if (k > 1) @(negedge clk);
      s_chk_valid     = (k - 1 == d);
      s_chk_bypass_en = (k - 1 == d) ? byp : 1'($urandom);
      if (k == 1) begin
        chk("chk_pulse", m_chk_valid, 1'b1);
        chk("chk_info", m_chk_pifo_info, info);
      end
      if (k == 2) chk("chk_pulse_once", m_chk_valid, 1'b0);
      chk("one_hot_valid", m_byp_valid & m_cal_valid, 1'b0);
      if (m_byp_valid || m_cal_valid) begin
        if (!seen) begin
          seen = 1; lat = k;
          ch   = m_byp_valid ? 0 : 1;
          data = m_byp_valid ? m_byp_pifo_info : m_cal_pifo_info;
        end else begin
          chk("out_chan_stable", m_byp_valid ? 0 : 1, ch);
          chk("out_data_stable", m_byp_valid ? m_byp_pifo_info : m_cal_pifo_info, data);
        end
        chk("axis_ready_busy", s_axis_ready, 1'b0);
        chk("chk_info_hold", m_chk_pifo_info, info);
        if (stray) begin s_chk_valid = 1'b1; s_chk_bypass_en = ~byp; end
        if (k - lat >= stall) begin
          if (m_byp_valid) m_byp_ready = 1'b1; else m_cal_ready = 1'b1;
          done = 1;
        end
      end
    end
    chk("out_handshake_seen", done, 1'b1);
    @(negedge clk);
    m_byp_ready = 1'b0; m_cal_ready = 1'b0; s_chk_valid = 1'b0;
    chk("ready_after_hs", s_axis_ready, 1'b1);
    chk("idle_byp_valid", m_byp_valid, 1'b0);
    chk("idle_cal_valid", m_cal_valid, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] info;
    int           d;
    logic         byp;
    int           stall;
    int           exp_ch;
    int           exp_lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[6];
    int           ch, lat;
    logic [W-1:0] data;
    logic [W-1:0] words[100];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] nxt;
    int           n_out;

    vecs[0] = '{32'h0000_00A5, 1,  1'b1, 0, 0, 3};   // bypass, answer one cycle after the pulse
    vecs[1] = '{32'h1234_5678, 0,  1'b0, 5, 1, 2};   // calendar with 5-cycle ready stall
    vecs[2] = '{32'hCAFE_0001, 99, 1'b1, 0, 1, 17};  // no answer -> timeout
    vecs[3] = '{32'h0BAD_0002, 15, 1'b1, 0, 0, 17};  // answer on the expiry cycle wins
    vecs[4] = '{32'h0BAD_0003, 14, 1'b0, 1, 1, 16};
    vecs[5] = '{32'h5A5A_A5A5, 0,  1'b1, 2, 0, 2};   // minimum latency

    rstn = 1'b0; s_axis_valid = 1'b0; s_axis_pifo_info = '0;
    s_chk_valid = 1'b0; s_chk_bypass_en = 1'b0; m_byp_ready = 1'b0; m_cal_ready = 1'b0;

    #1;
    chk("rst_axis_ready", s_axis_ready, 1'b0);
    chk("rst_chk_valid", m_chk_valid, 1'b0);
    chk("rst_byp_valid", m_byp_valid, 1'b0);
    chk("rst_cal_valid", m_cal_valid, 1'b0);
    chk("rst_info", m_cal_pifo_info, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", s_axis_ready, 1'b1);
    chk("post_rst_byp_info", m_byp_pifo_info, '0);
    check_stats("rst");

    for (int i = 0; i < 6; i++) begin
      do_item(vecs[i].info, vecs[i].d, vecs[i].byp, vecs[i].stall, 1'b0, 1'b0, '0, ch, data, lat);
      model_count(vecs[i].d, vecs[i].byp);
      chk($sformatf("vec%0d_chan", i), ch, vecs[i].exp_ch);
      chk($sformatf("vec%0d_data", i), data, vecs[i].info);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check_stats($sformatf("vec%0d", i));
    end

    // stray checker responses while idle
    for (int i = 0; i < 3; i++) begin
      s_chk_valid = 1'b1; s_chk_bypass_en = 1'b1;
      @(negedge clk);
      chk("stray_idle_ready", s_axis_ready, 1'b1);
      chk("stray_idle_pulse", m_chk_valid, 1'b0);
      chk("stray_idle_outs", m_byp_valid | m_cal_valid, 1'b0);
    end
    s_chk_valid = 1'b0;
    // stray responses while in BYP must not redirect the item
    do_item(32'h0000_0055, 0, 1'b1, 3, 1'b1, 1'b0, '0, ch, data, lat);
    model_count(0, 1'b1);
    chk("stray_byp_chan", ch, 0);
    chk("stray_byp_data", data, 32'h0000_0055);
    check_stats("stray");

    // reset while waiting for the checker
    s_axis_valid = 1'b1; s_axis_pifo_info = 32'hDEAD_BEEF;
    @(negedge clk);
    s_axis_valid = 1'b0;
    chk("beef_pulse", m_chk_valid, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_chk_valid", m_chk_valid, 1'b0);
    chk("midrst_byp_valid", m_byp_valid, 1'b0);
    chk("midrst_cal_valid", m_cal_valid, 1'b0);
    chk("midrst_ready", s_axis_ready, 1'b0);
    chk("midrst_info", m_chk_pifo_info, '0);
    @(negedge clk);
    rstn = 1'b1; m_byp = 0; m_cal = 0; m_tmo = 0;
    check_stats("midrst");
    @(negedge clk);
    chk("midrst_ready_back", s_axis_ready, 1'b1);
    do_item(32'h0000_0001, 1, 1'b0, 0, 1'b0, 1'b0, '0, ch, data, lat);
    model_count(1, 1'b0);
    chk("after_rst_chan", ch, 1);
    chk("after_rst_data", data, 32'h0000_0001);
    chk("after_rst_lat", lat, 3);
    check_stats("after_rst");

    // 100 random back-to-back items
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1; m_byp = 0; m_cal = 0; m_tmo = 0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) words[i] = $urandom;
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      int   d, st;
      logic b;
      d  = $urandom_range(0, 19);
      b  = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 3);
      if (i < 99) nxt = words[i + 1]; else nxt = '0;
      exp_q.push_back(words[i]);
      do_item(words[i], d, b, st, 1'b0, i < 99, nxt, ch, data, lat);
      if (ch >= 0) n_out++;
      chk($sformatf("rnd%0d_data", i), data, exp_q.pop_front());
      chk($sformatf("rnd%0d_chan", i), ch, exp_channel(d, b));
      chk($sformatf("rnd%0d_lat", i), lat, exp_latency(d));
      model_count(d, b);
    end
    chk("rnd_out_count", n_out, 100);
    chk("rnd_model_sum", m_byp + m_cal, 100);
    check_stats("rnd");
`ifdef DISPATCH_STATS_EN
    chk("rnd_stat_sum", stat_bypass_cnt + stat_enq_cnt, 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pifo_bypass_dispatcher.md
PIFO_BYPASS_DISPATCHER -- requirements
Module: pifo_bypass_dispatcher

Interface
REQ-001 Parameter PIFO_INFO_WIDTH, default 32, width of the PIFO info word.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum WAIT cycles before the default decision.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assertion, active-low.
REQ-005 s_axis_valid  input  1  upstream PIFO info valid.
REQ-006 s_axis_pifo_info  input  PIFO_INFO_WIDTH  upstream PIFO info.
REQ-007 s_axis_ready  output  1  dispatcher can accept an info word.
REQ-008 m_chk_valid  output  1  one-cycle request pulse to the bypass checker.
REQ-009 m_chk_pifo_info  output  PIFO_INFO_WIDTH  info word under check.
REQ-010 s_chk_valid  input  1  checker decision valid.
REQ-011 s_chk_bypass_en  input  1  1 = bypass the calendar queue, 0 = enqueue.
REQ-012 m_byp_valid / m_byp_pifo_info / m_byp_ready  output / output / input  1 / PIFO_INFO_WIDTH / 1  bypass path to the output queue.
REQ-013 m_cal_valid / m_cal_pifo_info / m_cal_ready  output / output / input  1 / PIFO_INFO_WIDTH / 1  enqueue path to the calendar queue.
REQ-014 stat_bypass_cnt, stat_enq_cnt  output  32 each; stat_timeout_cnt  output  16 (exist only with the macro of REQ-031).

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT, BYP and CAL.
REQ-016 IDLE: s_axis_ready=1; on s_axis_valid&&s_axis_ready, capture info into a holding register and go to WAIT.
REQ-017 s_axis_ready SHALL be 0 in every state except IDLE; one item is in flight at a time.
REQ-018 m_chk_valid SHALL be 1 only in the first cycle of WAIT; m_chk_pifo_info SHALL equal the held word throughout WAIT/BYP/CAL.
REQ-019 WAIT: s_chk_valid=1 SHALL move the FSM to BYP if s_chk_bypass_en=1, else to CAL; a response arriving in the pulse cycle itself is accepted.
REQ-020 WAIT: a timeout counter SHALL clear on entry and increment each cycle; on reaching TIMEOUT_CYCLES with no response, go to CAL (timeout event).
REQ-021 A response and timeout expiry in the same cycle SHALL take the response.
REQ-022 s_chk_valid outside WAIT SHALL be ignored.
REQ-023 BYP: m_byp_valid=1 with m_byp_pifo_info = held word, stable until m_byp_ready=1; on that handshake return to IDLE.
REQ-024 CAL: same as REQ-023 on the m_cal_* channel.
REQ-025 m_byp_valid and m_cal_valid SHALL never be 1 in the same cycle.
REQ-026 Minimum latency: capture edge N, request pulse in cycle N+1, response in N+1 gives output valid in N+2, and a new s_axis_ready in the cycle after the output handshake.

Reset
REQ-027 rstn=0 SHALL asynchronously force the FSM to IDLE and the holding register, timeout counter, every valid output and every stat counter to 0.
REQ-028 With rstn=0, s_axis_ready SHALL be 0; it becomes 1 in the first cycle after release.
REQ-029 Reset mid-operation SHALL drop the held item with no output handshake.
REQ-030 Data outputs SHALL read 0 after reset until the first capture.

Configuration
REQ-031 With DISPATCH_STATS_EN defined, the stat counters SHALL count bypass handshakes, calendar handshakes and timeout events, each saturating at all-ones.
REQ-032 Without DISPATCH_STATS_EN, the stat ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-033 The package pifo_dispatch_pkg SHALL hold the FSM state enum, the default PIFO_INFO_WIDTH and the default TIMEOUT_CYCLES.
REQ-034 The saturating statistics counter SHALL be the sub-module dispatch_stat_counter, instantiated three times only under DISPATCH_STATS_EN.

Verification
REQ-035 Info 0x0000_00A5, checker response bypass_en=1 one cycle after the pulse, m_byp_ready=1 -> m_byp_valid one cycle with 0x0000_00A5, m_cal_valid stays 0, stat_bypass_cnt=1.
REQ-036 Info 0x1234_5678, bypass_en=0, m_cal_ready held 0 for 5 cycles -> m_cal_valid=1 and data stable all 5 cycles, s_axis_ready=0, single handshake on ready.
REQ-037 No checker response -> m_cal_valid rises exactly TIMEOUT_CYCLES=16 cycles after WAIT entry, stat_timeout_cnt=1; a response landing on the expiry cycle with bypass_en=1 -> BYP, no timeout counted.
REQ-038 Stray s_chk_valid=1 while IDLE and during BYP -> no state change and no extra output.
REQ-039 rstn pulled low during WAIT with info 0xDEAD_BEEF -> all valids 0 immediately, no output for that word, next word 0x0000_0001 dispatched normally.
REQ-040 Back-to-back upstream valid for 100 random words and decisions -> output order equals input order, each word on exactly one channel, counter sum = 100.
